// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Bus between the MEM stage and the data memory.
//
// Signals (WORD_LEN wide unless noted):
//   writeEn      1 bit   store enable
//   readEn       1 bit   load enable
//   address              word address (ALU result)
//   dataIn               store data (from register file)
//   PC                   PC of the instruction in MEM (debug trace only)
//   instruction  16 bit  instruction word in MEM (debug trace only)
//   dataOut              load data (returned by the memory)
//
// Modports: master = pipeline side (drives requests), slave = memory side.
// -----------------------------------------------------------------------------
interface data_mem_if #(
   parameter int WORD_LEN = 16
);
   logic                writeEn;
   logic                readEn;
   logic [WORD_LEN-1:0] address;
   logic [WORD_LEN-1:0] dataIn;
   logic [WORD_LEN-1:0] PC;
   logic [15:0]         instruction;
   logic [WORD_LEN-1:0] dataOut;

   modport master (
      output writeEn, readEn, address, dataIn, PC, instruction,
      input  dataOut
   );

   modport slave (
      input  writeEn, readEn, address, dataIn, PC, instruction,
      output dataOut
   );
endinterface

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Data memory of the pipelined CPU's MEM stage. Single-port, word-organised
// RAM with synchronous write and combinational read.
//
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous, active-high; clears every word, wins over a write
//   bus  - data_mem_if.slave: writeEn, readEn, address, dataIn, PC,
//          instruction in; dataOut out
//
// Behaviour:
//   index   = address[ADDR_BITS-1:0]  (upper bits ignored, wraps modulo DEPTH)
//   write   : mem[index] <= dataIn on the edge when writeEn and not rst
//   dataOut = readEn ? mem[index] : 0, no write-through bypass
//
// Optional feature, macro DATAMEM_TRACE_EN:
//   When defined, a simulation-only trace prints one line per write, read or
//   reset edge. When undefined no display code is compiled and PC/instruction
//   are unused.
// -----------------------------------------------------------------------------
module data_mem #(
   parameter int WORD_LEN  = 16,
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = 8
) (
   input  logic       clk,
   input  logic       rst,
   data_mem_if.slave  bus
);

   logic [WORD_LEN-1:0]  mem [DEPTH];
   logic [ADDR_BITS-1:0] index;

   assign index = bus.address[ADDR_BITS-1:0];

   // Reset clears the whole array in one edge, so this is built from
   // registers rather than a block RAM primitive.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.writeEn) begin
         mem[index] <= bus.dataIn;
      end
   end

   // Combinational read: shows the pre-edge contents during a same-index
   // read/write, and the new data right after the edge.
   always_comb begin
      bus.dataOut = '0;
      if (bus.readEn) begin
         bus.dataOut = mem[index];
      end
   end

`ifdef DATAMEM_TRACE_EN
   // Simulation-only trace; never part of a synthesised build.
   always @(posedge clk) begin
      if (rst) begin
         $display("MEM RESET");
      end else begin
         if (bus.writeEn) begin
            $display("MEM WR PC=%0d INST=%b addr=%0d data=%b",
                     bus.PC, bus.instruction, bus.address, bus.dataIn);
         end
         if (bus.readEn) begin
            $display("MEM RD PC=%0d INST=%b addr=%0d data=%b",
                     bus.PC, bus.instruction, bus.address, bus.dataOut);
         end
      end
   end

   // Upper address bits never select a word.
   logic unusedAddrBits;
   assign unusedAddrBits = ^bus.address[WORD_LEN-1:ADDR_BITS];
`else
   // Debug-only inputs and the ignored upper address bits have no effect.
   logic unusedDebug;
   assign unusedDebug = ^{bus.PC, bus.instruction, bus.address[WORD_LEN-1:ADDR_BITS]};
`endif

endmodule

// File: tb/tb_data_mem.sv
// -----------------------------------------------------------------------------
// tb_data_mem
// Directed self-checking bench for data_mem. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1 time unit after each input change.
// -----------------------------------------------------------------------------
module tb_data_mem;

   logic clk = 1'b0;
   logic rst;

   int compared   = 0;
   int mismatched = 0;

   data_mem_if #(.WORD_LEN(16)) bus ();

   data_mem #(
      .WORD_LEN  (16),
      .DEPTH     (256),
      .ADDR_BITS (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] expected);
      compared++;
      assert (bus.dataOut === expected)
      else begin
         mismatched++;
         $error("FAIL %s: dataOut=%h expected=%h", tag, bus.dataOut, expected);
      end
      $display("check %-14s dataOut=%h expected=%h", tag, bus.dataOut, expected);
   endtask

   task automatic scramble_debug();
      bus.PC          = 16'($urandom);
      bus.instruction = 16'($urandom);
   endtask

   initial begin
      rst             = 1'b1;
      bus.writeEn     = 1'b0;
      bus.readEn      = 1'b0;
      bus.address     = '0;
      bus.dataIn      = '0;
      bus.PC          = '0;
      bus.instruction = '0;

      // 1. Reset clears memory
      tick();
      rst = 1'b0;
      settle();
      check("rst_noread", 16'h0000);
      bus.readEn = 1'b1;
      bus.address = 16'd0;   settle(); check("rst_addr0",   16'h0000);
      bus.address = 16'd5;   settle(); check("rst_addr5",   16'h0000);
      bus.address = 16'd255; settle(); check("rst_addr255", 16'h0000);

      // 2. Write then combinational read
      bus.readEn = 1'b0;
      bus.writeEn = 1'b1; bus.address = 16'd10; bus.dataIn = 16'hBEEF;
      scramble_debug();
      tick();
      bus.writeEn = 1'b0; bus.readEn = 1'b1; scramble_debug();
      settle(); check("wr_rd_10", 16'hBEEF);
      bus.readEn = 1'b0;
      settle(); check("rd_disabled", 16'h0000);

      // 3. Address wrap-around
      bus.writeEn = 1'b1; bus.address = 16'h0103; bus.dataIn = 16'h1234;
      scramble_debug();
      tick();
      bus.writeEn = 1'b0; bus.readEn = 1'b1;
      bus.address = 16'h0003; scramble_debug(); settle(); check("wrap_3",    16'h1234);
      bus.address = 16'hFF03; scramble_debug(); settle(); check("wrap_FF03", 16'h1234);
      bus.address = 16'h000A; settle(); check("keep_10", 16'hBEEF);

      // 4. Read during write, same index
      bus.readEn = 1'b0;
      bus.writeEn = 1'b1; bus.address = 16'd7; bus.dataIn = 16'h0001;
      tick();
      bus.readEn = 1'b1; bus.dataIn = 16'h0002; scramble_debug();
      settle(); check("rdw_before", 16'h0001);
      tick();
      bus.writeEn = 1'b0;
      settle(); check("rdw_after", 16'h0002);

      // 5. Reset priority over write, contents lost
      bus.readEn = 1'b0;
      bus.writeEn = 1'b1; bus.address = 16'd20; bus.dataIn = 16'hAAAA;
      tick();
      bus.writeEn = 1'b0; bus.readEn = 1'b1;
      settle(); check("pre_rst_20", 16'hAAAA);
      rst = 1'b1; bus.writeEn = 1'b1; bus.dataIn = 16'h5555;
      tick();
      rst = 1'b0; bus.writeEn = 1'b0;
      settle(); check("rst_prio_20", 16'h0000);
      bus.address = 16'd10; settle(); check("rst_lost_10", 16'h0000);
      bus.address = 16'd3;  settle(); check("rst_lost_3",  16'h0000);

      // 6. Debug inputs have no effect on stored data or dataOut
      bus.writeEn = 1'b1; bus.address = 16'd42; bus.dataIn = 16'hC3A5;
      tick();
      bus.writeEn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         scramble_debug();
         tick();
         check("debug_indep", 16'hC3A5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Absolute guard so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
